// File: rtl/start_token_reader.sv
// ============================================================================
// Module   : start_token_reader
// Brief    : Pops one start token from a start FIFO and runs one ap_ctrl_hs
//            start/ready/done handshake with the downstream process.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module start_token_reader #(
   parameter int DATA_WIDTH = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  if_empty_n,
   input  logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_read,
   output logic                  if_read_ce,
   output logic                  ap_start,
   input  logic                  ap_ready,
   input  logic                  ap_done,
   output logic [DATA_WIDTH-1:0] token_q,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  started_cnt,
   output logic [CNT_WIDTH-1:0]  done_cnt
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_START     = 2'd1;
   localparam logic [1:0] c_WAIT_DONE = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic                  r_ap_start;
   logic [DATA_WIDTH-1:0] r_token_q;
   logic [CNT_WIDTH-1:0]  r_started_cnt;
   logic [CNT_WIDTH-1:0]  r_done_cnt;
   logic                  w_pop;
   logic                  w_start_inc;
   logic                  w_done_inc;

   // Reset gating keeps the FIFO from losing a token to a pop that reset discards.
   assign w_pop       = (r_state == c_IDLE) & enable & if_empty_n & ~reset;
   assign w_start_inc = (r_state == c_START) & ap_ready;
   assign w_done_inc  = ((r_state == c_START) & ap_ready & ap_done)
                      | ((r_state == c_WAIT_DONE) & ap_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= c_IDLE;
         r_ap_start    <= 1'b0;
         r_token_q     <= '0;
         r_started_cnt <= '0;
         r_done_cnt    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ap_start <= (w_state_nxt == c_START);
         if (w_pop) begin
            r_token_q <= if_dout;
         end
         if (w_start_inc) begin
            r_started_cnt <= r_started_cnt + CNT_WIDTH'(1);
         end
         if (w_done_inc) begin
            r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // A done without ready in START is a stray and is ignored.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_pop) begin
               w_state_nxt = c_START;
            end
         end
         c_START: begin
            if (ap_ready) begin
               w_state_nxt = ap_done ? c_IDLE : c_WAIT_DONE;
            end
         end
         c_WAIT_DONE: begin
            if (ap_done) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      if_read     = w_pop;
      if_read_ce  = 1'b1;
      ap_start    = r_ap_start;
      token_q     = r_token_q;
      busy        = (r_state != c_IDLE);
      started_cnt = r_started_cnt;
      done_cnt    = r_done_cnt;
   end

endmodule

`default_nettype wire

// File: tb/tb_start_token_reader.sv
// ============================================================================
// Module   : tb_start_token_reader
// Brief    : Directed bench with a transaction-level model of the token reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_start_token_reader;

   localparam int DW = 4;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          if_empty_n;
   logic [DW-1:0] if_dout;
   logic          if_read;
   logic          if_read_ce;
   logic          ap_start;
   logic          ap_ready;
   logic          ap_done;
   logic [DW-1:0] token_q;
   logic          busy;
   logic [CW-1:0] started_cnt;
   logic [CW-1:0] done_cnt;

   int vectors = 0;
   int errors  = 0;
   int pops    = 0;

   start_token_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .if_empty_n  (if_empty_n),
      .if_dout     (if_dout),
      .if_read     (if_read),
      .if_read_ce  (if_read_ce),
      .ap_start    (ap_start),
      .ap_ready    (ap_ready),
      .ap_done     (ap_done),
      .token_q     (token_q),
      .busy        (busy),
      .started_cnt (started_cnt),
      .done_cnt    (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a token is either absent, awaiting acceptance, or accepted awaiting done.
   bit          m_valid     = 1'b0;
   bit          m_have_tok  = 1'b0;
   bit          m_accepted  = 1'b0;
   int          m_started   = 0;
   int          m_done      = 0;
   int          m_token     = 0;

   function automatic bit exp_if_read();
      return !m_have_tok && enable && if_empty_n && !reset;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_valid    = 1'b1;
         m_have_tok = 1'b0;
         m_accepted = 1'b0;
         m_started  = 0;
         m_done     = 0;
         m_token    = 0;
      end else if (m_valid) begin
         if (!m_have_tok) begin
            if (exp_if_read()) begin
               m_have_tok = 1'b1;
               m_accepted = 1'b0;
               m_token    = int'(if_dout);
            end
         end else if (!m_accepted) begin
            if (ap_ready) begin
               m_started = (m_started + 1) % (1 << CW);
               if (ap_done) begin
                  m_done     = (m_done + 1) % (1 << CW);
                  m_have_tok = 1'b0;
               end else begin
                  m_accepted = 1'b1;
               end
            end
         end else if (ap_done) begin
            m_done     = (m_done + 1) % (1 << CW);
            m_have_tok = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("if_read",     32'(if_read),     32'(exp_if_read()));
         check("if_read_ce",  32'(if_read_ce),  32'd1);
         check("ap_start",    32'(ap_start),    32'(m_have_tok && !m_accepted));
         check("busy",        32'(busy),        32'(m_have_tok));
         check("token_q",     32'(token_q),     32'(m_token));
         check("started_cnt", 32'(started_cnt), 32'(m_started));
         check("done_cnt",    32'(done_cnt),    32'(m_done));
         check("invariant",   32'(CW'(started_cnt - done_cnt) <= CW'(1)), 32'd1);
         check("read_empty",  32'(if_read && !if_empty_n), 32'd0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; if_empty_n = 1'b0; if_dout = '0;
      ap_ready = 1'b0; ap_done = 1'b0;

      // Reset state
      cyc(2);
      @(negedge clk);
      check("rst_ap_start", 32'(ap_start), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_token",    32'(token_q),  32'd0);
      check("rst_started",  32'(started_cnt), 32'd0);
      check("rst_done",     32'(done_cnt), 32'd0);
      cyc(1);

      // Single token: cycle 0 is the pop cycle
      reset = 1'b0; enable = 1'b1; if_empty_n = 1'b1; if_dout = 4'd1;
      @(negedge clk);
      check("t1_pop", 32'(if_read), 32'd1);
      cyc(1); if_empty_n = 1'b0;                       // cycle 1
      @(negedge clk);
      check("t1_ap_start", 32'(ap_start), 32'd1);
      check("t1_token",    32'(token_q),  32'd1);
      cyc(2); ap_ready = 1'b1;                         // cycle 3
      cyc(1); ap_ready = 1'b0;                         // cycle 4
      @(negedge clk);
      check("t1_start_drop", 32'(ap_start),    32'd0);
      check("t1_started",    32'(started_cnt), 32'd1);
      cyc(2); ap_done = 1'b1;                          // cycle 6
      cyc(1); ap_done = 1'b0;                          // cycle 7
      @(negedge clk);
      check("t1_done", 32'(done_cnt), 32'd1);
      check("t1_idle", 32'(busy),     32'd0);

      // Back-to-back combinational downstream
      reset = 1'b1; enable = 1'b0;
      cyc(1);
      reset = 1'b0; enable = 1'b1; if_empty_n = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if_read) pops++;
         cyc(1); if_dout = DW'(i + 2);
      end
      if_empty_n = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
      @(negedge clk);
      check("b2b_pops",    32'(pops),        32'd10);
      check("b2b_started", 32'(started_cnt), 32'd10);
      check("b2b_done",    32'(done_cnt),    32'd10);

      // Empty FIFO, then enable low with data present
      cyc(5);
      enable = 1'b0; if_empty_n = 1'b1; if_dout = 4'd9;
      cyc(3);
      @(negedge clk);
      check("gate_no_pop", 32'(busy), 32'd0);
      // Enable dropped during WAIT_DONE does not abort the handshake
      cyc(1); enable = 1'b1;
      cyc(1); enable = 1'b0; ap_ready = 1'b1;
      cyc(1); ap_ready = 1'b0;
      cyc(2); ap_done = 1'b1;
      cyc(1); ap_done = 1'b0;
      @(negedge clk);
      check("gate_started", 32'(started_cnt), 32'd11);
      check("gate_done",    32'(done_cnt),    32'd11);
      check("gate_token",   32'(token_q),     32'd9);

      // Stray done in START
      if_dout = 4'd5; enable = 1'b1;
      cyc(1); enable = 1'b0; ap_done = 1'b1;
      cyc(2);
      @(negedge clk);
      check("stray_ap_start", 32'(ap_start), 32'd1);
      check("stray_done",     32'(done_cnt), 32'd11);
      ap_done = 1'b0; ap_ready = 1'b1;
      cyc(1); ap_ready = 1'b0;
      @(negedge clk);
      check("stray_started", 32'(started_cnt), 32'd12);
      cyc(1); ap_done = 1'b1;
      cyc(1); ap_done = 1'b0;
      @(negedge clk);
      check("stray_done2", 32'(done_cnt), 32'd12);

      // Reset while in WAIT_DONE
      if_dout = 4'd7; enable = 1'b1;
      cyc(1); ap_ready = 1'b1;
      cyc(1); ap_ready = 1'b0;
      cyc(1); reset = 1'b1;
      @(negedge clk);
      check("rst_mid_no_pop", 32'(if_read), 32'd0);
      cyc(1); reset = 1'b0; enable = 1'b0;
      @(negedge clk);
      check("rst_mid_ap_start", 32'(ap_start),    32'd0);
      check("rst_mid_busy",     32'(busy),        32'd0);
      check("rst_mid_started",  32'(started_cnt), 32'd0);
      check("rst_mid_done",     32'(done_cnt),    32'd0);

      // Counter wrap: 17 combinational tokens on a 4-bit counter
      enable = 1'b1; if_empty_n = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
      for (int i = 0; i < 34; i++) begin
         cyc(1); if_dout = DW'(i * 3);
      end
      enable = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
      @(negedge clk);
      check("wrap_started", 32'(started_cnt), 32'd1);
      check("wrap_done",    32'(done_cnt),    32'd1);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
